tlm_tx_scheduler: RTL and testbench

TLM_TX_SCHEDULER -- requirements
Module: tlm_tx_scheduler

---
 rtl/pid_pkg.sv | 41 ++++
 rtl/tlm_period_counter.sv | 58 +++++
 rtl/tlm_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_tlm_tx_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// ============================================================================
// Module : pid_pkg
// Brief  : Shared telemetry framing constants, scheduler state encoding and
//          the frame byte selector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pid_pkg;

  localparam logic [7:0] TLM_HEADER    = 8'hA5;
  localparam int         TLM_FRAME_LEN = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOST_SEND = 3'd1,
    HOST_WAIT = 3'd2,
    TLM_SEND  = 3'd3,
    TLM_WAIT  = 3'd4
  } state_t;

  // Byte k of a telemetry frame; the last byte is the XOR of the four payload bytes.
  function automatic logic [7:0] tlm_byte(input logic [2:0]  idx,
                                          input logic [15:0] pid,
                                          input logic [15:0] sens);
    logic [7:0] b;
    case (idx)
      3'd0:    b = TLM_HEADER;
      3'd1:    b = pid[15:8];
      3'd2:    b = pid[7:0];
      3'd3:    b = sens[15:8];
      3'd4:    b = sens[7:0];
      3'd5:    b = pid[15:8] ^ pid[7:0] ^ sens[15:8] ^ sens[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlm_period_counter.sv
// ============================================================================
// Module : tlm_period_counter
// Brief  : Telemetry period timebase with pending flag and overrun pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlm_period_counter #(
  parameter int TLM_DIV = 1000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_clk_en,
  input  logic i_enable,
  input  logic i_clr_pending,
  output logic o_pending,
  output logic o_overrun
);

  logic [15:0] r_cnt;
  logic        r_pending;
  logic        r_overrun;
  logic        w_wrap;

  assign w_wrap = i_enable && i_clk_en && (r_cnt == 16'(TLM_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_cnt     <= 16'd0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (!i_enable) begin
        r_cnt     <= 16'd0;
        r_pending <= 1'b0;
      end else begin
        if (i_clk_en) begin
          r_cnt <= w_wrap ? 16'd0 : r_cnt + 16'd1;
        end
        // A wrap coinciding with the scheduler taking the flag is a fresh
        // frame request, not an overrun.
        if (w_wrap) begin
          r_pending <= 1'b1;
          r_overrun <= r_pending && !i_clr_pending;
        end else if (i_clr_pending) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/tlm_tx_scheduler.sv
// ============================================================================
// Module : tlm_tx_scheduler
// Brief  : Shares one UART transmitter between host bytes and periodic
//          6-byte telemetry frames with round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlm_tx_scheduler
  import pid_pkg::*;
#(
  parameter int TLM_DIV = 1000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        clk_en_i,
  input  logic        tlm_enable_i,
  input  logic [15:0] pid_data_i,
  input  logic [15:0] sens_data_i,
  input  logic        host_send_i,
  input  logic [7:0]  host_data_i,
  output logic        host_busy_o,
  input  logic        ser_busy_i,
  output logic        ser_send_o,
  output logic [7:0]  ser_data_o,
  output logic        tlm_overrun_o
);

  state_t      r_state, w_next;
  logic        r_hold_valid;
  logic [7:0]  r_hold_data;
  logic [15:0] r_pid, r_sens;
  logic [2:0]  r_idx;
  logic        r_prefer_tlm;
  logic        r_seen_busy;
  logic        r_ser_send;
  logic [7:0]  r_ser_data;

  logic        w_pending, w_conflict, w_grant_host, w_grant_tlm;
  logic        w_send, w_wait_done, w_last_byte;
  logic [7:0]  w_byte;

  tlm_period_counter #(.TLM_DIV(TLM_DIV)) u_period (
    .clk_in        (clk_in),
    .reset         (reset),
    .i_clk_en      (clk_en_i),
    .i_enable      (tlm_enable_i),
    .i_clr_pending (w_grant_tlm),
    .o_pending     (w_pending),
    .o_overrun     (tlm_overrun_o)
  );

  assign w_conflict  = (r_state == IDLE) && r_hold_valid && w_pending;
  assign w_last_byte = (r_idx == 3'(TLM_FRAME_LEN - 1));
  assign w_byte      = (r_state == HOST_SEND) ? r_hold_data : tlm_byte(r_idx, r_pid, r_sens);

  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant_host = 1'b0;
    w_grant_tlm  = 1'b0;
    w_send       = 1'b0;
    w_wait_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_conflict) begin
          w_grant_tlm  = r_prefer_tlm;
          w_grant_host = !r_prefer_tlm;
        end else begin
          w_grant_host = r_hold_valid;
          w_grant_tlm  = w_pending;
        end
        if (w_grant_host)     w_next = HOST_SEND;
        else if (w_grant_tlm) w_next = TLM_SEND;
      end
      HOST_SEND, TLM_SEND: begin
        if (!ser_busy_i) begin
          w_send = 1'b1;
          w_next = (r_state == HOST_SEND) ? HOST_WAIT : TLM_WAIT;
        end
      end
      HOST_WAIT, TLM_WAIT: begin
        if (r_seen_busy && !ser_busy_i) begin
          w_wait_done = 1'b1;
          if (r_state == HOST_WAIT || w_last_byte) w_next = IDLE;
          else                                     w_next = TLM_SEND;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= 8'h00;
      r_pid        <= 16'h0000;
      r_sens       <= 16'h0000;
      r_idx        <= 3'd0;
      r_prefer_tlm <= 1'b0;
      r_seen_busy  <= 1'b0;
      r_ser_send   <= 1'b0;
      r_ser_data   <= 8'h00;
    end else begin
      r_ser_send <= w_send;
      if (w_send) r_ser_data <= w_byte;
      if (w_grant_tlm) begin
        r_pid  <= pid_data_i;
        r_sens <= sens_data_i;
        r_idx  <= 3'd0;
      end else if (r_state == TLM_WAIT && w_wait_done && !w_last_byte) begin
        r_idx <= r_idx + 3'd1;
      end
      // The pointer only moves on a real conflict so conflicts alternate.
      if (w_conflict) r_prefer_tlm <= !r_prefer_tlm;
      if (w_send)          r_seen_busy <= 1'b0;
      else if (ser_busy_i) r_seen_busy <= 1'b1;
      if (r_state == HOST_WAIT && w_wait_done) begin
        r_hold_valid <= 1'b0;
        r_hold_data  <= 8'h00;
      end else if (host_send_i && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= host_data_i;
      end
    end
  end

  assign host_busy_o = r_hold_valid;
  assign ser_send_o  = r_ser_send;
  assign ser_data_o  = r_ser_data;

endmodule

`default_nettype wire

// File: tb/tb_tlm_tx_scheduler.sv
// ============================================================================
// Module : tb_tlm_tx_scheduler
// Brief  : Self-checking bench for tlm_tx_scheduler with a UART model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlm_tx_scheduler;

  localparam int DIV = 4;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en_i = 1'b0;
  logic        tlm_enable_i = 1'b0;
  logic [15:0] pid_data_i = 16'h0000;
  logic [15:0] sens_data_i = 16'h0000;
  logic        host_send_i = 1'b0;
  logic [7:0]  host_data_i = 8'h00;
  logic        host_busy_o;
  logic        ser_busy_i;
  logic        ser_send_o;
  logic [7:0]  ser_data_o;
  logic        tlm_overrun_o;

  tlm_tx_scheduler #(.TLM_DIV(DIV)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .clk_en_i      (clk_en_i),
    .tlm_enable_i  (tlm_enable_i),
    .pid_data_i    (pid_data_i),
    .sens_data_i   (sens_data_i),
    .host_send_i   (host_send_i),
    .host_data_i   (host_data_i),
    .host_busy_o   (host_busy_o),
    .ser_busy_i    (ser_busy_i),
    .ser_send_o    (ser_send_o),
    .ser_data_o    (ser_data_o),
    .tlm_overrun_o (tlm_overrun_o)
  );

  always #5 clk_in = ~clk_in;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sent_q[$];
  int         ucnt = 0;
  logic       force_busy = 1'b0;
  logic       uart_rst = 1'b0;
  int         ovr_cnt = 0;
  logic [7:0] last_sent = 8'h00;

  typedef struct {
    logic [15:0] pid;
    logic [15:0] sens;
    logic [47:0] exp;
  } vec_t;
  vec_t tbl[6];

  assign ser_busy_i = force_busy || (ucnt > 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // UART model: accepts a strobe, stays busy for a random number of cycles.
  always @(negedge clk_in) begin
    if (tlm_overrun_o) ovr_cnt++;
    if (uart_rst) begin
      ucnt      = 0;
      last_sent = 8'h00;
    end else begin
      if (ucnt > 0 && !force_busy) chk("data_hold", ser_data_o, last_sent);
      if (ser_send_o) begin
        chk("send_while_busy", ucnt, 0);
        sent_q.push_back(ser_data_o);
        last_sent = ser_data_o;
        ucnt = $urandom_range(1, 5);
      end else if (ucnt > 0) begin
        ucnt--;
      end
    end
  end

  function automatic logic [7:0] model_byte(input logic [15:0] pid, input logic [15:0] sens, input int k);
    logic [7:0] f [6];
    f[0] = 8'hA5;
    f[1] = pid[15:8];
    f[2] = pid[7:0];
    f[3] = sens[15:8];
    f[4] = sens[7:0];
    f[5] = 8'h00;
    for (int j = 1; j < 5; j++) f[5] = f[5] ^ f[j];
    return f[k];
  endfunction

  function automatic logic [7:0] pop_byte();
    if (sent_q.size() == 0) return 8'hxx;
    return sent_q.pop_front();
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    uart_rst = 1'b1;
    clk_en_i = 1'b0;
    host_send_i = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    uart_rst = 1'b0;
    sent_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic pulse_en(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      clk_en_i = 1'b1;
      @(negedge clk_in);
      clk_en_i = 1'b0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk_in);
    end
  endtask

  task automatic wait_bytes(input int n, input string name);
    int budget;
    budget = 2000;
    while (sent_q.size() < n && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    chk({name, "_count"}, sent_q.size(), n);
  endtask

  task automatic wait_host_idle(input string name);
    int budget;
    budget = 200;
    while (host_busy_o && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    chk(name, host_busy_o, 1'b0);
  endtask

  task automatic expect_frame(input string name, input logic [15:0] pid, input logic [15:0] sens);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_b%0d", name, k), pop_byte(), model_byte(pid, sens, k));
  endtask

  initial begin
    logic [7:0]  exp_q[$];
    logic [15:0] p, s;
    logic [7:0]  hb;
    logic [47:0] e;

    tbl[0] = '{16'h1234, 16'h00FF, 48'hA5_1234_00FF_D9};
    tbl[1] = '{16'h0000, 16'h0000, 48'hA5_0000_0000_00};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 48'hA5_FFFF_FFFF_00};
    tbl[3] = '{16'hA55A, 16'h0F0F, 48'hA5_A55A_0F0F_FF};
    tbl[4] = '{16'h8001, 16'h4002, 48'hA5_8001_4002_C3};
    tbl[5] = '{16'hDEAD, 16'hBEEF, 48'hA5_DEAD_BEEF_22};

    do_reset();
    @(negedge clk_in);
    chk("rst_ser_send", ser_send_o, 1'b0);
    chk("rst_ser_data", ser_data_o, 8'h00);
    chk("rst_host_busy", host_busy_o, 1'b0);
    chk("rst_overrun", tlm_overrun_o, 1'b0);

    // Fixed frames: no frame before the DIV-th pulse, then exact bytes.
    tlm_enable_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      sent_q.delete();
      pid_data_i  = tbl[v].pid;
      sens_data_i = tbl[v].sens;
      e = tbl[v].exp;
      pulse_en(DIV - 1, 1);
      repeat (20) @(negedge clk_in);
      chk($sformatf("tbl%0d_early", v), sent_q.size(), 0);
      pulse_en(1, 0);
      wait_bytes(6, $sformatf("tbl%0d", v));
      for (int k = 0; k < 6; k++)
        chk($sformatf("tbl%0d_b%0d", v, k), pop_byte(), e[47 - 8*k -: 8]);
      repeat (10) @(negedge clk_in);
    end

    // Host byte arriving mid-frame waits for the frame; a second request is ignored.
    sent_q.delete();
    pid_data_i = 16'h1234; sens_data_i = 16'h00FF;
    pulse_en(DIV, 0);
    wait_bytes(2, "host_mid_pre");
    host_data_i = 8'h5A; host_send_i = 1'b1;
    @(negedge clk_in);
    host_send_i = 1'b0;
    chk("host_busy_rise", host_busy_o, 1'b1);
    host_data_i = 8'h77; host_send_i = 1'b1;
    @(negedge clk_in);
    host_send_i = 1'b0;
    wait_bytes(7, "host_mid");
    expect_frame("host_mid_frame", 16'h1234, 16'h00FF);
    chk("host_mid_byte", pop_byte(), 8'h5A);
    wait_host_idle("host_busy_fall");
    repeat (30) @(negedge clk_in);
    chk("host_ignored", sent_q.size(), 0);

    // Round-robin: first conflict host wins, second telemetry wins.
    do_reset();
    tlm_enable_i = 1'b1;
    pid_data_i = 16'h0102; sens_data_i = 16'h0304;
    pulse_en(DIV - 1, 0);
    host_data_i = 8'h3C; host_send_i = 1'b1; clk_en_i = 1'b1;
    @(negedge clk_in);
    host_send_i = 1'b0; clk_en_i = 1'b0;
    wait_bytes(7, "rr1");
    chk("rr1_host_first", pop_byte(), 8'h3C);
    expect_frame("rr1_frame", 16'h0102, 16'h0304);
    repeat (10) @(negedge clk_in);
    pulse_en(DIV - 1, 0);
    host_data_i = 8'hC3; host_send_i = 1'b1; clk_en_i = 1'b1;
    @(negedge clk_in);
    host_send_i = 1'b0; clk_en_i = 1'b0;
    wait_bytes(7, "rr2");
    expect_frame("rr2_frame", 16'h0102, 16'h0304);
    chk("rr2_host_last", pop_byte(), 8'hC3);
    repeat (10) @(negedge clk_in);

    // UART stuck busy: one frame taken, two more periods give one overrun.
    do_reset();
    tlm_enable_i = 1'b1;
    pid_data_i = 16'h4321; sens_data_i = 16'h8765;
    force_busy = 1'b1;
    pulse_en(DIV, 0);
    repeat (3) @(negedge clk_in);
    chk("ovr_none_yet", ovr_cnt, 0);
    pulse_en(2 * DIV, 1);
    repeat (4) @(negedge clk_in);
    chk("ovr_once", ovr_cnt, 1);
    force_busy = 1'b0;
    wait_bytes(12, "ovr_frames");
    expect_frame("ovr_f1", 16'h4321, 16'h8765);
    expect_frame("ovr_f2", 16'h4321, 16'h8765);
    repeat (40) @(negedge clk_in);
    chk("ovr_no_extra", sent_q.size(), 0);
    chk("ovr_final", ovr_cnt, 1);

    // Reset in the middle of a frame.
    sent_q.delete();
    pid_data_i = 16'hCAFE; sens_data_i = 16'hF00D;
    pulse_en(DIV, 0);
    wait_bytes(4, "midrst_pre");
    reset = 1'b0;
    @(negedge clk_in);
    uart_rst = 1'b1;
    chk("midrst_send", ser_send_o, 1'b0);
    chk("midrst_data", ser_data_o, 8'h00);
    chk("midrst_busy", host_busy_o, 1'b0);
    chk("midrst_ovr", tlm_overrun_o, 1'b0);
    @(negedge clk_in);
    reset = 1'b1;
    uart_rst = 1'b0;
    sent_q.delete();
    repeat (40) @(negedge clk_in);
    chk("midrst_silent", sent_q.size(), 0);
    pulse_en(DIV, 0);
    wait_bytes(6, "midrst_next");
    expect_frame("midrst_next", 16'hCAFE, 16'hF00D);
    repeat (10) @(negedge clk_in);

    // Disable clears the count; pulses while disabled do nothing.
    sent_q.delete();
    pid_data_i = 16'h1111; sens_data_i = 16'h2222;
    pulse_en(2, 0);
    tlm_enable_i = 1'b0;
    repeat (2) @(negedge clk_in);
    pulse_en(2 * DIV + 1, 0);
    repeat (20) @(negedge clk_in);
    chk("dis_silent", sent_q.size(), 0);
    tlm_enable_i = 1'b1;
    pulse_en(DIV - 1, 0);
    repeat (20) @(negedge clk_in);
    chk("dis_cnt_zero", sent_q.size(), 0);
    pulse_en(1, 0);
    wait_bytes(6, "dis_after");
    expect_frame("dis_after", 16'h1111, 16'h2222);
    repeat (10) @(negedge clk_in);

    // Random: optional host byte then a frame whose inputs change mid-frame.
    for (int it = 0; it < 10; it++) begin
      sent_q.delete();
      exp_q.delete();
      p = 16'($urandom);
      s = 16'($urandom);
      pid_data_i = p; sens_data_i = s;
      if ($urandom_range(0, 1) == 1) begin
        hb = 8'($urandom);
        exp_q.push_back(hb);
        host_data_i = hb; host_send_i = 1'b1;
        @(negedge clk_in);
        host_send_i = 1'b0;
        wait_host_idle($sformatf("rnd%0d_host", it));
      end
      pulse_en(DIV, 2);
      wait_bytes(exp_q.size() + 1, $sformatf("rnd%0d_start", it));
      pid_data_i = 16'($urandom);
      sens_data_i = 16'($urandom);
      for (int k = 0; k < 6; k++) exp_q.push_back(model_byte(p, s, k));
      wait_bytes(exp_q.size(), $sformatf("rnd%0d", it));
      for (int k = 0; k < exp_q.size(); k++)
        chk($sformatf("rnd%0d_b%0d", it, k), pop_byte(), exp_q[k]);
      repeat (10) @(negedge clk_in);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
